// File: rtl/par_serializer.sv
// par_serializer: LSB-first word serializer with an optional even-parity trailer.
// Feeds the serial parity generator; sof/eof mark frame boundaries downstream.
module par_serializer #(
    parameter int WIDTH         = 8,
    parameter bit APPEND_PARITY = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             sof,
    output logic             eof,
    output logic             busy
);
    localparam int FL = WIDTH + (APPEND_PARITY ? 1 : 0);
    localparam int CW = $clog2(FL + 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRE_LAST  = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PAR
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_n;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic             par;
    logic             par_n;
    logic             x_n;
    logic             x_valid_n;
    logic             sof_n;
    logic             eof_n;
    logic             busy_n;
    logic             accept;
    logic             last_data;

    // Ready when idle or while the final bit of a frame is on x,
    // which lets frames run back-to-back with no gap.
    assign din_ready = rst_n && ((state == IDLE) || eof);
    assign accept    = din_valid && din_ready;
    assign last_data = (state == SHIFT) && (cnt == LAST_DATA);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            par     <= 1'b0;
            x       <= 1'b0;
            x_valid <= 1'b0;
            sof     <= 1'b0;
            eof     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            cnt     <= cnt_n;
            par     <= par_n;
            x       <= x_n;
            x_valid <= x_valid_n;
            sof     <= sof_n;
            eof     <= eof_n;
            busy    <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        if (accept) begin
            state_n = SHIFT;
        end else begin
            case (state)
                IDLE:    state_n = IDLE;
                SHIFT:   if (last_data) state_n = APPEND_PARITY ? PAR : IDLE;
                PAR:     state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // cnt tracks the index of the bit currently on x.
    always_comb begin
        shreg_n   = '0;
        cnt_n     = '0;
        par_n     = 1'b0;
        x_n       = 1'b0;
        x_valid_n = 1'b0;
        sof_n     = 1'b0;
        eof_n     = 1'b0;
        busy_n    = 1'b0;
        if (accept) begin
            shreg_n   = din >> 1;
            par_n     = ^din;
            x_n       = din[0];
            x_valid_n = 1'b1;
            sof_n     = 1'b1;
            busy_n    = 1'b1;
            eof_n     = (FL == 1);
        end else if ((state == SHIFT) && !last_data) begin
            shreg_n   = shreg >> 1;
            cnt_n     = cnt + 1'b1;
            par_n     = par;
            x_n       = shreg[0];
            x_valid_n = 1'b1;
            busy_n    = 1'b1;
            eof_n     = !APPEND_PARITY && (cnt == PRE_LAST);
        end else if (last_data && APPEND_PARITY) begin
            cnt_n     = cnt + 1'b1;
            x_n       = par;
            x_valid_n = 1'b1;
            eof_n     = 1'b1;
            busy_n    = 1'b1;
        end
    end
endmodule

// File: tb/tb_par_serializer.sv
// Scoreboard bench for par_serializer: a parity build (index 1)
// and a data-only build (index 0) share clock and reset.
module tb_par_serializer;
    typedef struct packed {
        logic x;
        logic sof;
        logic eof;
    } bit_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0][7:0] din;
    logic [1:0]      vld;
    logic [1:0]      rdy;
    logic [1:0]      xs;
    logic [1:0]      xv;
    logic [1:0]      sof;
    logic [1:0]      eof;
    logic [1:0]      busy;
    logic [1:0]      acc;
    bit_t            q [2][$];
    bit              mon_en = 1'b0;
    int              n_cmp = 0;
    int              n_err = 0;

    always #5 clk = ~clk;

    par_serializer #(.WIDTH(8), .APPEND_PARITY(1'b0)) u_nop (
        .clk(clk), .rst_n(rst_n), .din(din[0]), .din_valid(vld[0]),
        .din_ready(rdy[0]), .x(xs[0]), .x_valid(xv[0]),
        .sof(sof[0]), .eof(eof[0]), .busy(busy[0])
    );

    par_serializer #(.WIDTH(8), .APPEND_PARITY(1'b1)) u_par (
        .clk(clk), .rst_n(rst_n), .din(din[1]), .din_valid(vld[1]),
        .din_ready(rdy[1]), .x(xs[1]), .x_valid(xv[1]),
        .sof(sof[1]), .eof(eof[1]), .busy(busy[1])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame(input int p, input logic [7:0] w);
        logic par = 1'b0;
        for (int i = 0; i < 8; i++) begin
            par = par ^ w[i];
            q[p].push_back('{x: w[i], sof: (i == 0), eof: (p == 0 && i == 7)});
        end
        if (p == 1) q[p].push_back('{x: par, sof: 1'b0, eof: 1'b1});
    endtask

    // Present w and hold it until the handshake completes.
    task automatic send(input int p, input logic [7:0] w);
        int n = 0;
        din[p] = w;
        vld[p] = 1'b1;
        while (rdy[p] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            check("ready_timeout", 32'(rdy[p]), 32'd1);
            vld[p] = 1'b0;
        end else begin
            @(posedge clk);
            push_frame(p, w);
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        vld = 2'b00;
        repeat (n) @(negedge clk);
    endtask

    task automatic mon_one(input int p);
        bit_t e;
        logic exp_rdy;
        if (q[p].size() > 0) begin
            e = q[p][0];
            if (xv[p] !== 1'b1) begin
                check($sformatf("gap%0d", p), 32'(xv[p]), 32'd1);
                return;
            end
            void'(q[p].pop_front());
            check($sformatf("bit%0d", p),
                  32'({xs[p], sof[p], eof[p], busy[p]}),
                  32'({e.x, e.sof, e.eof, 1'b1}));
            acc[p] = acc[p] ^ xs[p];
            if (e.eof) begin
                if (p == 1) check("frame_parity", 32'(acc[p]), 32'd0);
                acc[p] = 1'b0;
            end
            exp_rdy = rst_n & e.eof;
        end else begin
            check($sformatf("idle%0d", p),
                  32'({xv[p], xs[p], sof[p], eof[p], busy[p]}), 32'd0);
            exp_rdy = rst_n;
        end
        check($sformatf("ready%0d", p), 32'(rdy[p]), 32'(exp_rdy));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_one(0);
            mon_one(1);
        end
    end

    initial begin
        rst_n = 1'b0;
        din   = {8'hFF, 8'hFF};
        vld   = 2'b11;
        acc   = 2'b00;
        @(posedge clk);
        #1 mon_en = 1'b1;
        repeat (3) @(negedge clk);
        vld = 2'b00;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        send(1, 8'hB4);
        idle(12);
        send(1, 8'h07);
        idle(12);

        send(1, 8'hB4);
        send(1, 8'h07);
        idle(12);

        send(1, 8'hB4);
        idle(3);
        send(1, 8'hFF);
        idle(12);

        // Abort a frame while bit 3 is on x.
        send(1, 8'hB4);
        idle(2);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        q[0].delete();
        q[1].delete();
        acc = 2'b00;
        idle(4);
        send(1, 8'h07);
        idle(12);

        send(0, 8'hB4);
        send(0, 8'h07);
        idle(12);

        check("drain0", 32'(q[0].size()), 32'd0);
        check("drain1", 32'(q[1].size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
